// File: rtl/wall_collide_if.sv
// Bundles the player/step/wall inputs and the collision results of
// wall_collide.
//   slave  : the collision checker (takes geometry, drives results)
//   master : the player/wall logic (drives geometry, takes results)
// Signals:
//   Player_X/Y, Player_Size : player centre and half-extent (unsigned)
//   Step_X/Y                : proposed motion this frame (two's complement)
//   X1..X4, Y1..Y4          : wall top-left corners
//   block_x/block_y         : proposed X/Y move collides with some wall
//   hit_wall                : bit i-1 set when wall i caused a block
//   busy/done/overrun       : check status, result strobe, sticky late tick
interface wall_collide_if;
  logic [9:0] Player_X, Player_Y, Player_Size;
  logic [9:0] Step_X, Step_Y;
  logic [9:0] X1, X2, X3, X4, Y1, Y2, Y3, Y4;
  logic       block_x, block_y;
  logic [3:0] hit_wall;
  logic       busy, done, overrun;

  modport slave (
    input  Player_X, Player_Y, Player_Size, Step_X, Step_Y,
           X1, X2, X3, X4, Y1, Y2, Y3, Y4,
    output block_x, block_y, hit_wall, busy, done, overrun
  );

  modport master (
    output Player_X, Player_Y, Player_Size, Step_X, Step_Y,
           X1, X2, X3, X4, Y1, Y2, Y3, Y4,
    input  block_x, block_y, hit_wall, busy, done, overrun
  );
endinterface

// File: rtl/wall_collide.sv
// Per-frame player/wall collision checker.
// On each rising edge of frame_clk (sampled in the Clk domain) it latches the
// player, step and wall geometry, then checks one wall per cycle for four
// cycles, and finally publishes block_x/block_y/hit_wall with a one-cycle
// done pulse (5 Clk edges after the tick-detect edge).
// Ports:
//   Clk       : system clock
//   Reset     : synchronous, active-high
//   frame_clk : slow frame tick, edge-detected against prev_fc
//   bus       : wall_collide_if.slave (geometry in, results/status out)
module wall_collide #(
  parameter logic [9:0] Hor_Width   = 10'd64,
  parameter logic [9:0] Hor_Height  = 10'd32,
  parameter logic [9:0] Vert_Width  = 10'd32,
  parameter logic [9:0] Vert_Height = 10'd64
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_clk,
  wall_collide_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef struct packed {
    logic [9:0]      px, py, ps;
    logic [9:0]      sx, sy;
    logic [3:0][9:0] wx, wy;
  } req_t;

  logic [1:0] state;
  logic [1:0] idx;
  logic       prev_fc;
  req_t       req;
  logic       acc_x, acc_y;
  logic [3:0] acc_hit;

  wire tick = frame_clk & ~prev_fc;

  // Everything widened to 12-bit signed so box edges that go below zero stay
  // negative instead of aliasing to large coordinates.
  logic signed [11:0] px, py, ps, cx, cy;
  logic signed [11:0] wxl, wxh, wyl, wyh;
  logic               hit_x, hit_y;

  function automatic logic overlap(input logic signed [11:0] a_lo, a_hi,
                                   input logic signed [11:0] b_lo, b_hi);
    return (a_lo <= b_hi) && (a_hi >= b_lo);
  endfunction

  always_comb begin
    px  = {2'b00, req.px};
    py  = {2'b00, req.py};
    ps  = {2'b00, req.ps};
    cx  = px + {{2{req.sx[9]}}, req.sx};
    cy  = py + {{2{req.sy[9]}}, req.sy};
    wxl = {2'b00, req.wx[idx]};
    wyl = {2'b00, req.wy[idx]};
    // Walls 1 and 3 (idx 0,2) are horizontal, 2 and 4 (idx 1,3) vertical.
    wxh = wxl + {2'b00, (idx[0] ? Vert_Width  : Hor_Width)};
    wyh = wyl + {2'b00, (idx[0] ? Vert_Height : Hor_Height)};
    hit_x = overlap(cx - ps, cx + ps, wxl, wxh) &&
            overlap(py - ps, py + ps, wyl, wyh);
    hit_y = overlap(px - ps, px + ps, wxl, wxh) &&
            overlap(cy - ps, cy + ps, wyl, wyh);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      idx          <= 2'd0;
      prev_fc      <= 1'b1;  // frame_clk high at release is not a tick
      req          <= '0;
      acc_x        <= 1'b0;
      acc_y        <= 1'b0;
      acc_hit      <= 4'd0;
      bus.block_x  <= 1'b0;
      bus.block_y  <= 1'b0;
      bus.hit_wall <= 4'd0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overrun  <= 1'b0;
    end else begin
      prev_fc  <= frame_clk;
      bus.done <= 1'b0;
      if (tick && state != IDLE) bus.overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          req.px  <= bus.Player_X;
          req.py  <= bus.Player_Y;
          req.ps  <= bus.Player_Size;
          req.sx  <= bus.Step_X;
          req.sy  <= bus.Step_Y;
          req.wx  <= {bus.X4, bus.X3, bus.X2, bus.X1};
          req.wy  <= {bus.Y4, bus.Y3, bus.Y2, bus.Y1};
          acc_x   <= 1'b0;
          acc_y   <= 1'b0;
          acc_hit <= 4'd0;
          idx     <= 2'd0;
          bus.busy <= 1'b1;
          state   <= CHECK;
        end
        CHECK: begin
          if (hit_x) acc_x <= 1'b1;
          if (hit_y) acc_y <= 1'b1;
          if (hit_x || hit_y) acc_hit[idx] <= 1'b1;
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= DONE;
        end
        DONE: begin
          bus.block_x  <= acc_x;
          bus.block_y  <= acc_y;
          bus.hit_wall <= acc_hit;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wall_collide.md
WALL_COLLIDE -- requirements
Module: wall_collide

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  Hor_Width 10'd64, extent of walls 1 and 3 in X;
  Hor_Height 10'd32, extent of walls 1 and 3 in Y;
  Vert_Width 10'd32, extent of walls 2 and 4 in X;
  Vert_Height 10'd64, extent of walls 2 and 4 in Y.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
  Clk  in  1  system clock, 50 MHz;
  Reset  in  1  synchronous, active-high;
  frame_clk  in  1  frame tick, ~60 Hz, asynchronous to Clk phase but slow;
  Player_X, Player_Y  in  10  player centre, unsigned;
  Player_Size  in  10  player half-extent, unsigned;
  Step_X, Step_Y  in  10  proposed motion this frame, two's complement;
  X1..X4, Y1..Y4  in  10 each  wall top-left corners from wall stage;
  block_x  out  1  proposed X move collides with some wall;
  block_y  out  1  proposed Y move collides with some wall;
  hit_wall  out  4  bit i-1 set when wall i caused either block;
  busy  out  1  check in progress;
  done  out  1  one-cycle result-valid pulse;
  overrun  out  1  sticky: frame tick arrived while busy.

Function
REQ-004 Frame edge: frame_clk is registered into prev_fc every Clk edge; a tick is detected at the Clk edge where frame_clk = 1 and prev_fc = 0.
REQ-005 States: IDLE, CHECK, DONE; CHECK carries a 2-bit wall index idx.
REQ-006 IDLE + tick: latch all player, step and wall inputs; clear accumulators; idx <= 0; go to CHECK; busy = 1.
REQ-007 CHECK: each cycle evaluates wall idx+1 from the latched values; idx increments; after idx = 3, go to DONE.
REQ-008 DONE: copy accumulators to block_x, block_y, hit_wall; done = 1 for exactly that cycle; busy = 0; next state IDLE.
REQ-009 Latency: done is high during the cycle starting at the 5th Clk edge after the tick-detect edge.
REQ-010 Result outputs hold their values until the next DONE.
REQ-011 Wall box (inclusive): [WX, WX+W] x [WY, WY+H], using Hor_* for walls 1 and 3 and Vert_* for walls 2 and 4.
REQ-012 Player box: [CX-S, CX+S] x [CY-S, CY+S], all inclusive.
REQ-013 X check: box with CX = Player_X + Step_X and CY = Player_Y overlaps the wall box, i.e. both ranges intersect with inclusive bounds.
REQ-014 Y check: box with CX = Player_X and CY = Player_Y + Step_Y overlaps the wall box.
REQ-015 All arithmetic is 12-bit signed with zero-extended unsigned inputs and sign-extended steps; no wrap, so negative edges never alias to large coordinates.
REQ-016 An X-check hit ORs into block_x; a Y-check hit ORs into block_y; either hit sets hit_wall[idx].
REQ-017 A tick in CHECK or DONE is ignored (no restart, no re-latch) and sets overrun = 1; overrun clears only on Reset.
REQ-018 Input changes after latching do not affect the current check.

Reset
REQ-019 Reset forces: state IDLE, idx 0, accumulators 0, block_x/block_y/hit_wall/done/busy/overrun 0.
REQ-020 prev_fc resets to 1, so a frame_clk held high at reset release does not trigger a check.
REQ-021 Reset mid-CHECK aborts the check; no done pulse follows.

Verification
REQ-022 Walls (150,150),(200,250),(450,300),(400,100); player (100,166), Size 4, Step_X +47, Step_Y 0; tick -> done on the 5th edge; block_x=1, block_y=0, hit_wall=0001.
REQ-023 Same as REQ-022 but Step_X +45 (right edge 149) -> block_x=0, block_y=0, hit_wall=0000.
REQ-024 Player (216,240), Size 4, Step_X 0, Step_Y +6 (bottom edge 250 = wall 2 top) -> block_y=1, block_x=0, hit_wall=0010.
REQ-025 Second frame_clk rise two cycles after the first -> exactly one done pulse; overrun=1; results match the first-latched inputs.
REQ-026 Reset asserted in the 2nd CHECK cycle -> all outputs 0 next cycle; no done pulse; a later tick runs normally.
REQ-027 Player (2,2), Size 4, Step_X -3, Step_Y -3 -> no wrap-around false hit; block_x=0, block_y=0, hit_wall=0000.
